// File: rtl/night_rider_monitor.sv
// night_rider_monitor: receive-side checker for a one-hot night-rider LED bus.
// Samples led_in on led_valid and decodes it to an index. It locks onto the
// bounce 0..N-1..0 and reports position, direction, endpoint bounces and errors.
// Optional build macro: NR_MON_REPEAT_TOL_EN, which tolerates up to MAX_REPEAT
// consecutive identical samples while tracking.

module night_rider_monitor #(
    parameter int N          = 8,
    parameter int CNT_W      = 16,
    parameter int MAX_REPEAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         led_in,
    input  logic                 led_valid,
    output logic [$clog2(N)-1:0] pos,
    output logic                 dir,
    output logic                 locked,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [CNT_W-1:0]     sweep_cnt
);

    localparam int PW = $clog2(N);

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_SEQ    = 2'b10;
    localparam logic [1:0] ERR_REPEAT = 2'b11;

    // An illegal configuration stops elaboration instead of producing silent misbehaviour.
    if (N < 3 || MAX_REPEAT < 1) begin : g_bad_params
        $error("night_rider_monitor: N must be >= 3 and MAX_REPEAT must be >= 1");
    end

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_TRACK  = 1'b1
    } state_t;

    state_t            r_state, w_state_nx;
    logic [PW-1:0]     r_pos, w_pos_nx;
    logic              r_dir, w_dir_nx;
    logic              r_locked, w_locked_nx;
    logic              r_err, w_err_nx;
    logic [1:0]        r_code, w_code_nx;
    logic [CNT_W-1:0]  r_sweep, w_sweep_nx;

    logic              w_onehot;
    logic [PW-1:0]     w_idx;
    logic [PW-1:0]     w_exp;
    logic              w_hit;

`ifdef NR_MON_REPEAT_TOL_EN
    localparam int RW = $clog2(MAX_REPEAT + 1);
    logic [RW-1:0]     r_rpt, w_rpt_nx;
    logic              w_same;
`endif

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_onehot = (led_in != '0) && ((led_in & (led_in - N'(1))) == '0);

    // Priority-free decode: OR together the indices of every set bit; only
    // meaningful when w_onehot is true, which gates every use of w_idx.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (led_in[i]) begin
                w_idx = w_idx | PW'(i);
            end
        end
    end

    // Next index the scanner must show. In TRACK, dir is always 1 at pos 0 and 0 at N-1,
    // so this never has to wrap.
    assign w_exp = r_dir ? (r_pos + PW'(1)) : (r_pos - PW'(1));
    assign w_hit = (w_idx == w_exp);

`ifdef NR_MON_REPEAT_TOL_EN
    assign w_same = (w_idx == r_pos);
`endif

    // Next-state and next-output decision for each valid sample.
    always_comb begin
        w_state_nx  = r_state;
        w_pos_nx    = r_pos;
        w_dir_nx    = r_dir;
        w_locked_nx = r_locked;
        w_err_nx    = 1'b0;
        w_code_nx   = r_code;
        w_sweep_nx  = r_sweep;
`ifdef NR_MON_REPEAT_TOL_EN
        w_rpt_nx    = r_rpt;
`endif
        if (led_valid) begin
            if (!w_onehot) begin
                w_err_nx    = 1'b1;
                w_code_nx   = ERR_ONEHOT;
                w_state_nx  = S_SEARCH;
                w_locked_nx = 1'b0;
`ifdef NR_MON_REPEAT_TOL_EN
                w_rpt_nx    = '0;
`endif
            end else begin
                unique case (r_state)
                    S_SEARCH: begin
                        // Only an endpoint identifies the direction, so only endpoints lock.
                        if (led_in[0]) begin
                            w_pos_nx    = '0;
                            w_dir_nx    = 1'b1;
                            w_locked_nx = 1'b1;
                            w_state_nx  = S_TRACK;
                        end else if (led_in[N-1]) begin
                            w_pos_nx    = PW'(N - 1);
                            w_dir_nx    = 1'b0;
                            w_locked_nx = 1'b1;
                            w_state_nx  = S_TRACK;
                        end
`ifdef NR_MON_REPEAT_TOL_EN
                        w_rpt_nx = '0;
`endif
                    end
                    S_TRACK: begin
                        if (w_hit) begin
                            w_pos_nx = w_idx;
                            if (w_idx == PW'(N - 1)) begin
                                w_dir_nx   = 1'b0;
                                w_sweep_nx = r_sweep + CNT_W'(1);
                            end else if (w_idx == '0) begin
                                w_dir_nx   = 1'b1;
                                w_sweep_nx = r_sweep + CNT_W'(1);
                            end
`ifdef NR_MON_REPEAT_TOL_EN
                            w_rpt_nx = '0;
                        end else if (w_same) begin
                            // A stalled scanner is tolerated for a bounded number of samples.
                            if (r_rpt == RW'(MAX_REPEAT)) begin
                                w_err_nx    = 1'b1;
                                w_code_nx   = ERR_REPEAT;
                                w_state_nx  = S_SEARCH;
                                w_locked_nx = 1'b0;
                                w_rpt_nx    = '0;
                            end else begin
                                w_rpt_nx = r_rpt + RW'(1);
                            end
`endif
                        end else begin
                            w_err_nx    = 1'b1;
                            w_code_nx   = ERR_SEQ;
                            w_state_nx  = S_SEARCH;
                            w_locked_nx = 1'b0;
`ifdef NR_MON_REPEAT_TOL_EN
                            w_rpt_nx    = '0;
`endif
                        end
                    end
                    default: begin
                        w_state_nx  = S_SEARCH;
                        w_locked_nx = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset takes effect immediately, without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_SEARCH;
            r_pos    <= '0;
            r_dir    <= 1'b1;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= ERR_NONE;
            r_sweep  <= '0;
`ifdef NR_MON_REPEAT_TOL_EN
            r_rpt    <= '0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_pos    <= w_pos_nx;
            r_dir    <= w_dir_nx;
            r_locked <= w_locked_nx;
            r_err    <= w_err_nx;
            r_code   <= w_code_nx;
            r_sweep  <= w_sweep_nx;
`ifdef NR_MON_REPEAT_TOL_EN
            r_rpt    <= w_rpt_nx;
`endif
        end
    end

    assign pos       = r_pos;
    assign dir       = r_dir;
    assign locked    = r_locked;
    assign err       = r_err;
    assign err_code  = r_code;
    assign sweep_cnt = r_sweep;

endmodule

// File: tb/tb_night_rider_monitor.sv
// tb_night_rider_monitor: table-driven bench with an expected-result queue.
// Two monitors share the same stimulus: the main one uses CNT_W=16 and the second
// uses CNT_W=2, so the second one's sweep counter wraps. Build with
// NR_MON_REPEAT_TOL_EN defined to exercise repeat tolerance with MAX_REPEAT=2.

module tb_night_rider_monitor;

    logic        clk;
    logic        rst;
    logic [7:0]  led_in;
    logic        led_valid;

    logic [2:0]  pos,  pos2;
    logic        dir,  dir2;
    logic        locked, locked2;
    logic        err,  err2;
    logic [1:0]  err_code, err_code2;
    logic [15:0] sweep_cnt;
    logic [1:0]  sweep_cnt2;

    night_rider_monitor #(.N(8), .CNT_W(16), .MAX_REPEAT(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .led_in    (led_in),
        .led_valid (led_valid),
        .pos       (pos),
        .dir       (dir),
        .locked    (locked),
        .err       (err),
        .err_code  (err_code),
        .sweep_cnt (sweep_cnt)
    );

    night_rider_monitor #(.N(8), .CNT_W(2), .MAX_REPEAT(2)) u_dut_w2 (
        .clk       (clk),
        .rst       (rst),
        .led_in    (led_in),
        .led_valid (led_valid),
        .pos       (pos2),
        .dir       (dir2),
        .locked    (locked2),
        .err       (err2),
        .err_code  (err_code2),
        .sweep_cnt (sweep_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rb;     // pulse reset before applying this vector
        logic [7:0]  led;
        logic        vld;
        logic [2:0]  pos;
        logic        dir;
        logic        lk;
        logic        err;
        logic [1:0]  code;
        logic [15:0] sw;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(bit rb, logic [7:0] led, logic vld, logic [2:0] p, logic d,
                                logic lk, logic e, logic [1:0] c, logic [15:0] sw);
        vec_t v;
        v.rb = rb; v.led = led; v.vld = vld; v.pos = p; v.dir = d;
        v.lk = lk; v.err = e; v.code = c; v.sw = sw;
        return v;
    endfunction

    // Compare both monitors against one expectation; the narrow one sees sw modulo 4.
    task automatic check(string name, vec_t e);
        logic [23:0] act, ex;
        logic [9:0]  act2, ex2;
        act  = {pos, dir, locked, err, err_code, sweep_cnt};
        ex   = {e.pos, e.dir, e.lk, e.err, e.code, e.sw};
        n_chk++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got pos=%0d dir=%0d locked=%0d err=%0d code=%0d sweep=%0d, expected pos=%0d dir=%0d locked=%0d err=%0d code=%0d sweep=%0d",
                     name, pos, dir, locked, err, err_code, sweep_cnt,
                     e.pos, e.dir, e.lk, e.err, e.code, e.sw);
        end
        act2 = {pos2, dir2, locked2, err2, err_code2, sweep_cnt2};
        ex2  = {e.pos, e.dir, e.lk, e.err, e.code, e.sw[1:0]};
        n_chk++;
        if (act2 !== ex2) begin
            n_fail++;
            $display("FAIL %s (cnt_w2): got %h, expected %h", name, act2, ex2);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        led_valid = 1'b0;
        led_in    = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one sample, queue its expectation, and compare once the registered output appears.
    task automatic step(string name, vec_t v);
        vec_t e;
        @(negedge clk);
        led_in    = v.led;
        led_valid = v.vld;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: expectation queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, e);
        end
    endtask

    initial begin
        int   mpos, mdir, msw, nxt;
        vec_t v;

        rst       = 1'b1;
        led_in    = 8'h00;
        led_valid = 1'b0;
        #1;
        check("reset_values", mk(0, 8'h00, 0, 3'd0, 1, 0, 0, 2'd0, 16'd0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Legal bounce 0..7..0: two endpoint bounces, no error.
        tbl.push_back(mk(1, 8'h01, 1, 3'd0, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h04, 1, 3'd2, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h08, 1, 3'd3, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h10, 1, 3'd4, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h20, 1, 3'd5, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h40, 1, 3'd6, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h80, 1, 3'd7, 0, 1, 0, 2'd0, 16'd1));
        tbl.push_back(mk(0, 8'h40, 1, 3'd6, 0, 1, 0, 2'd0, 16'd1));
        tbl.push_back(mk(0, 8'h20, 1, 3'd5, 0, 1, 0, 2'd0, 16'd1));
        tbl.push_back(mk(0, 8'h10, 1, 3'd4, 0, 1, 0, 2'd0, 16'd1));
        tbl.push_back(mk(0, 8'h08, 1, 3'd3, 0, 1, 0, 2'd0, 16'd1));
        tbl.push_back(mk(0, 8'h04, 1, 3'd2, 0, 1, 0, 2'd0, 16'd1));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 0, 1, 0, 2'd0, 16'd1));
        tbl.push_back(mk(0, 8'h01, 1, 3'd0, 1, 1, 0, 2'd0, 16'd2));
        // Not one-hot while locked (two bits, then zero bits), then an idle cycle.
        tbl.push_back(mk(1, 8'h01, 1, 3'd0, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h06, 1, 3'd1, 1, 0, 1, 2'd1, 16'd0));
        tbl.push_back(mk(0, 8'h00, 1, 3'd1, 1, 0, 1, 2'd1, 16'd0));
        tbl.push_back(mk(0, 8'h00, 0, 3'd1, 1, 0, 0, 2'd1, 16'd0));
        // Not one-hot while searching.
        tbl.push_back(mk(1, 8'h03, 1, 3'd0, 1, 0, 1, 2'd1, 16'd0));
        // Skip, then immediate relock at the top endpoint; the error code stays sticky.
        tbl.push_back(mk(1, 8'h01, 1, 3'd0, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h08, 1, 3'd1, 1, 0, 1, 2'd2, 16'd0));
        tbl.push_back(mk(0, 8'h80, 1, 3'd7, 0, 1, 0, 2'd2, 16'd0));
        // Lock rules and valid gating with garbage on the bus.
        tbl.push_back(mk(1, 8'h10, 1, 3'd0, 1, 0, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h80, 1, 3'd7, 0, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'hFF, 0, 3'd7, 0, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h00, 0, 3'd7, 0, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h01, 0, 3'd7, 0, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h40, 0, 3'd7, 0, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h33, 0, 3'd7, 0, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h40, 1, 3'd6, 0, 1, 0, 2'd0, 16'd0));
        // Repeated sample.
`ifdef NR_MON_REPEAT_TOL_EN
        tbl.push_back(mk(1, 8'h01, 1, 3'd0, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 0, 1, 2'd3, 16'd0));
        tbl.push_back(mk(1, 8'h01, 1, 3'd0, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h04, 1, 3'd2, 1, 1, 0, 2'd0, 16'd0));
`else
        tbl.push_back(mk(1, 8'h01, 1, 3'd0, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 1, 0, 2'd0, 16'd0));
        tbl.push_back(mk(0, 8'h02, 1, 3'd1, 1, 0, 1, 2'd2, 16'd0));
`endif

        foreach (tbl[i]) begin
            if (tbl[i].rb) do_reset();
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Four endpoint bounces from a model: the wide counter reaches 4, the 2-bit one wraps to 0.
        do_reset();
        step("wrap_lock", mk(0, 8'h01, 1, 3'd0, 1, 1, 0, 2'd0, 16'd0));
        mpos = 0; mdir = 1; msw = 0;
        for (int s = 0; s < 30; s++) begin
            nxt = (mdir == 1) ? mpos + 1 : mpos - 1;
            mpos = nxt;
            if (nxt == 7) begin mdir = 0; msw++; end
            if (nxt == 0) begin mdir = 1; msw++; end
            v = mk(0, 8'(1 << nxt), 1, 3'(mpos), 1'(mdir), 1, 0, 2'd0, 16'(msw));
            step($sformatf("wrap%0d", s), v);
        end
        n_chk++;
        if (sweep_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL sweep_wide: got %0d, expected 4", sweep_cnt);
        end
        n_chk++;
        if (sweep_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL sweep_wrap: got %0d, expected 0", sweep_cnt2);
        end

        // Asynchronous reset mid-sweep, away from any clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", mk(0, 8'h00, 0, 3'd0, 1, 0, 0, 2'd0, 16'd0));
        @(negedge clk);
        rst = 1'b0;
        step("post_reset_mid", mk(0, 8'h04, 1, 3'd0, 1, 0, 0, 2'd0, 16'd0));
        step("post_reset_lock", mk(0, 8'h01, 1, 3'd0, 1, 1, 0, 2'd0, 16'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
